// File: rtl/spi_slave_pro.sv
// SPI slave supporting all CPOL/CPHA modes, with valid/ready TX holding register and RX output.
// Optional frame counter output enabled by defining SPI_SLAVE_PRO_FRAME_CNT_EN.
module spi_slave_pro #(
  parameter int DATA_WIDTH  = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int LSB_FIRST   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  sclk_i,
  input  logic                  mosi_i,
  input  logic                  cs_n_i,
  output logic                  miso_o,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_valid_o,
  input  logic                  rx_ready_i,
  output logic                  rx_ovr_o,
  output logic                  tx_udr_o,
  output logic                  busy_o
`ifdef SPI_SLAVE_PRO_FRAME_CNT_EN
  ,
  output logic [15:0]           frame_cnt_o
`endif
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
  localparam logic CPOL_BIT = (CPOL != 0);
  localparam logic CPHA_BIT = (CPHA != 0);
  localparam logic LSB_BIT  = (LSB_FIRST != 0);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t state, next_state;

  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync;
  logic                   sclk_prev, cs_prev;
  logic [CNT_W-1:0]       bit_cnt;
  logic [DATA_WIDTH-1:0]  rx_shift, tx_shift, hold_data;
  logic                   hold_full;

  logic sclk_s, mosi_s, cs_s;
  logic rise, fall, lead_edge, trail_edge, sample_edge, shift_edge;
  logic cs_fall, cs_rise, in_frame, do_sample, do_shift, word_done, load, shift_tx;
  logic [DATA_WIDTH-1:0] rx_next, tx_next, load_word;

  // Idle levels on reset so no spurious edge or chip-select fall is seen after reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sclk_sync <= {SYNC_STAGES{CPOL_BIT}};
      mosi_sync <= '0;
      cs_sync   <= '1;
      sclk_prev <= CPOL_BIT;
      cs_prev   <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_i};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_i};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n_i};
      sclk_prev <= sclk_sync[SYNC_STAGES-1];
      cs_prev   <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s      = sclk_sync[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync[SYNC_STAGES-1];
  assign cs_s        = cs_sync[SYNC_STAGES-1];
  assign rise        = sclk_s & ~sclk_prev;
  assign fall        = ~sclk_s & sclk_prev;
  assign lead_edge   = CPOL_BIT ? fall : rise;
  assign trail_edge  = CPOL_BIT ? rise : fall;
  assign sample_edge = CPHA_BIT ? trail_edge : lead_edge;
  assign shift_edge  = CPHA_BIT ? lead_edge : trail_edge;
  assign cs_fall     = cs_prev & ~cs_s;
  assign cs_rise     = ~cs_prev & cs_s;

  assign in_frame  = (state == ACTIVE) & ~cs_rise;
  assign do_sample = in_frame & sample_edge;
  assign do_shift  = in_frame & shift_edge;
  assign word_done = do_sample & (bit_cnt == LAST_BIT);

  // With CPHA=0 the next word is already presented at word completion, so the following
  // shift edge (bit counter back at 0) must not shift it away.
  assign load     = CPHA_BIT ? (do_shift & (bit_cnt == '0))
                             : (((state == IDLE) & cs_fall) | word_done);
  assign shift_tx = do_shift & ~load & (CPHA_BIT | (bit_cnt != '0));

  assign rx_next   = LSB_BIT ? {mosi_s, rx_shift[DATA_WIDTH-1:1]} : {rx_shift[DATA_WIDTH-2:0], mosi_s};
  assign tx_next   = LSB_BIT ? {1'b0, tx_shift[DATA_WIDTH-1:1]} : {tx_shift[DATA_WIDTH-2:0], 1'b0};
  assign load_word = hold_full ? hold_data : '0;

  assign miso_o     = (state == ACTIVE) & (LSB_BIT ? tx_shift[0] : tx_shift[DATA_WIDTH-1]);
  assign busy_o     = (state == ACTIVE);
  assign tx_ready_o = ~hold_full;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (cs_fall) next_state = ACTIVE;
      ACTIVE:  if (cs_rise) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bit_cnt    <= '0;
      rx_shift   <= '0;
      tx_shift   <= '0;
      hold_data  <= '0;
      hold_full  <= 1'b0;
      rx_data_o  <= '0;
      rx_valid_o <= 1'b0;
      rx_ovr_o   <= 1'b0;
      tx_udr_o   <= 1'b0;
    end else begin
      rx_ovr_o <= 1'b0;
      tx_udr_o <= 1'b0;
      if ((state == ACTIVE) && cs_rise) begin
        bit_cnt  <= '0;
        rx_shift <= '0;
        tx_shift <= '0;
      end else begin
        if (do_sample) begin
          rx_shift <= rx_next;
          bit_cnt  <= word_done ? '0 : bit_cnt + 1'b1;
        end
        if (load) begin
          tx_shift <= load_word;
          tx_udr_o <= ~hold_full;
        end else if (shift_tx) begin
          tx_shift <= tx_next;
        end
      end
      // A handshake coinciding with a load refills the holding register after the load consumed it.
      if (tx_valid_i && !hold_full) begin
        hold_full <= 1'b1;
        hold_data <= tx_data_i;
      end else if (load) begin
        hold_full <= 1'b0;
      end
      if (word_done) begin
        if (rx_valid_o && !rx_ready_i) begin
          rx_ovr_o <= 1'b1;
        end else begin
          rx_data_o  <= rx_next;
          rx_valid_o <= 1'b1;
        end
      end else if (rx_valid_o && rx_ready_i) begin
        rx_valid_o <= 1'b0;
      end
    end
  end

`ifdef SPI_SLAVE_PRO_FRAME_CNT_EN
  // Counts only words that actually reached rx_data_o; saturates rather than wrapping.
  always_ff @(posedge clk_i) begin
    if (rst_i || ((state == IDLE) && cs_fall)) begin
      frame_cnt_o <= '0;
    end else if (word_done && !(rx_valid_o && !rx_ready_i) && (frame_cnt_o != 16'hFFFF)) begin
      frame_cnt_o <= frame_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: doc/spi_slave_pro.md
Name: spi_slave_pro

Overview:
Parametrised SPI slave for the peripheral bus. Supports all four CPOL/CPHA modes, configurable word width and MSB/LSB-first ordering. Input pins are synchronised internally, TX and RX use valid/ready handshakes, and overrun/underrun are flagged. It sits between an external SPI master and on-chip register or FIFO logic, with everything in the clk_i domain.

Parameters:
DATA_WIDTH, 8, word width in bits; range 4..32
CPOL, 0, idle SCLK level
CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge
LSB_FIRST, 0, 1 = LSB shifted first on both MOSI and MISO
SYNC_STAGES, 2, synchroniser depth on sclk_i, mosi_i and cs_n_i; minimum 2

Ports:
clk_i  in  1  system clock; must be at least 4x SCLK frequency
rst_i  in  1  reset. One clock; reset is synchronous and active-high.
sclk_i  in  1  SPI clock, asynchronous
mosi_i  in  1  SPI data in, asynchronous
cs_n_i  in  1  chip select, active-low, asynchronous
miso_o  out  1  SPI data out; driven 0 while deselected
tx_data_i  in  DATA_WIDTH  next word to transmit
tx_valid_i  in  1  tx_data_i valid
tx_ready_o  out  1  TX holding register empty
rx_data_o  out  DATA_WIDTH  last received word
rx_valid_o  out  1  rx_data_o valid
rx_ready_i  in  1  consumer accepts rx_data_o
rx_ovr_o  out  1  one-cycle pulse: completed word dropped
tx_udr_o  out  1  one-cycle pulse: word started with empty holding register
busy_o  out  1  chip select active (synchronised)

Behaviour:
- Reset values: miso_o=0, tx_ready_o=1, rx_data_o=0, rx_valid_o=0, rx_ovr_o=0, tx_udr_o=0, busy_o=0, bit counter=0, shift registers=0, FSM=IDLE. Reset applied mid-frame discards the partial word and the holding register.
- Synchronisers: SYNC_STAGES flops per input. Edge detect compares the last synchronised SCLK stage with its previous value.
- Leading edge is rising if CPOL=0, falling if CPOL=1. The sample edge is the leading edge if CPHA=0, otherwise the trailing edge. The shift edge is the other edge.
- FSM states: IDLE, ACTIVE.
  - IDLE->ACTIVE when synced cs_n falls.
  - ACTIVE->IDLE when synced cs_n rises. A partial word is discarded, the bit counter clears, and miso_o=0.
  - busy_o = (state==ACTIVE).
- Word load into the TX shift register:
  - CPHA=0: on the cs_n-fall cycle, and on the cycle of the DATA_WIDTH-th sample edge while still ACTIVE.
  - CPHA=1: on the first shift edge of each word (bit counter==0).
  - The load takes the holding register if full, which then empties and tx_ready_o rises next cycle. If the holding register is empty, the load takes all-zeros and tx_udr_o pulses.
- TX shifting: on the other shift edges the register shifts toward the output end. miso_o is the MSB, or the LSB when LSB_FIRST=1.
- TX holding register: the handshake fires when tx_valid_i & tx_ready_o; tx_ready_o falls the next cycle. If the handshake and a load occur in the same cycle, the load takes the old contents and the holding register takes the new word (tx_ready_o stays 0).
- RX: each sample edge shifts in synced MOSI and increments the bit counter modulo DATA_WIDTH.
  - On the DATA_WIDTH-th sample edge, rx_data_o and rx_valid_o=1 update on the next clk cycle.
  - rx_valid_o clears on rx_valid_o & rx_ready_i.
  - If a word completes while rx_valid_o=1 and rx_ready_i=0, the new word is dropped, rx_data_o is unchanged and rx_ovr_o pulses.
  - If completion coincides with rx_ready_i=1, the new word is accepted and rx_valid_o stays 1.
- Edges seen while IDLE are ignored.

Optional Feature:
- Macro: SPI_SLAVE_PRO_FRAME_CNT_EN.
- Defined: adds output frame_cnt_o [15:0].
  - Counts completed words accepted into rx_data_o since cs_n fell.
  - Clears on cs_n fall and on reset; saturates at 16'hFFFF.
  - Dropped (overrun) words are not counted.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Mode 0, DATA_WIDTH=8, MSB first: preload tx 8'hA5, master sends 8'h3C -> MISO bits 1,0,1,0,0,1,0,1; rx_data_o=8'h3C with a one-cycle-late rx_valid_o; tx_ready_o=1 after load.
- Each of modes 1, 2, 3 plus LSB_FIRST=1: master sends 8'h81, slave tx 8'h01 -> rx_data_o=8'h81; master samples 8'h01 in LSB-first order.
- Back-to-back words 8'h11, 8'h22 with rx_ready_i held 0 -> rx_data_o=8'h11, one rx_ovr_o pulse; then rx_ready_i=1 clears rx_valid_o.
- No TX data preloaded, 8-bit transfer -> MISO all 0 and one tx_udr_o pulse; rx is still received correctly.
- cs_n deasserted after 5 bits, then a full 8'hF0 word -> no rx_valid_o for the partial word; rx_data_o=8'hF0 with the counter restarted.
- rst_i pulsed after bit 3 of a frame -> all outputs at reset values next cycle. With SPI_SLAVE_PRO_FRAME_CNT_EN, 3 words give frame_cnt_o=3, cleared on the next cs_n fall.
